instr_sequencer: RTL

- Program-driven issuer that feeds the register-file instruction processor.
- Holds a small instruction program loaded through a write port. On start, it presents one instruction at a time on the processor's instr/reg1/reg2/reg3/const inputs.
- Uses the processor's done signal as the issue/complete handshake, and holds every field stable for the whole execution.
- Sits between the testbench or host loader and the processor.

---
 rtl/instr_sequencer_if.sv | 36 +++
 rtl/instr_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
//   Instruction bus between the program sequencer and the register-file
//   instruction processor.
//
//   Signals:
//     instr     [2:0]   processor opcode
//     reg1      [4:0]   read address 1
//     reg2      [4:0]   read address 2
//     reg3      [4:0]   write address
//     const_val [15:0]  constant operand ("const" is a reserved word)
//     done              processor done flag, doubles as issue/complete
//                       handshake
//
//   Modports:
//     master  the sequencer: drives the instruction fields, reads done
//     slave   the processor: reads the instruction fields, drives done
// ---------------------------------------------------------------------------
interface instr_sequencer_if;
    logic [2:0]  instr;
    logic [4:0]  reg1;
    logic [4:0]  reg2;
    logic [4:0]  reg3;
    logic [15:0] const_val;
    logic        done;

    modport master (
        output instr, reg1, reg2, reg3, const_val,
        input  done
    );

    modport slave (
        input  instr, reg1, reg2, reg3, const_val,
        output done
    );
endinterface

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Holds a small instruction program written through a load port and, on
//   start, feeds it one word at a time to the register-file instruction
//   processor. The processor's done flag is the handshake: at every clock
//   edge with done high the processor begins executing whatever fields are
//   present, so the next word is selected combinationally from done and
//   appears in time for the edge at which the processor restarts. While no
//   program word is being presented the bus shows a harmless idle read
//   (opcode 001, all other fields zero).
//
//   Ports:
//     clk, rst_n    clock, synchronous active-low reset
//     load_en       write program word (dropped while busy)
//     load_addr     program write address
//     load_data     {instr[33:31], reg1[30:26], reg2[25:21], reg3[20:16],
//                    const[15:0]}
//     prog_len      number of words to run (0..DEPTH), sampled on start
//     start         begin a run (ignored while busy)
//     bus           instruction fields out, done in (master modport)
//     busy          run in progress
//     finished      high from run completion until the next start
//     issue_count   words issued in the current run
//     timeout_err   watchdog fired
//
//   Optional feature, macro ISSUE_TIMEOUT_EN:
//     When defined, a watchdog counts consecutive busy cycles with done low;
//     after TIMEOUT of them the run is abandoned and timeout_err is set
//     (sticky until reset or the next start). When undefined there is no
//     counter and timeout_err is constant 0.
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_en,
    input  logic [ADDR_W-1:0]     load_addr,
    input  logic [33:0]           load_data,
    input  logic [ADDR_W:0]       prog_len,
    input  logic                  start,
    instr_sequencer_if.master     bus,
    output logic                  busy,
    output logic                  finished,
    output logic [ADDR_W:0]       issue_count,
    output logic                  timeout_err
);

    localparam logic [33:0]   IDLE_WORD = {3'b001, 31'd0};
    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

    logic [33:0]     mem [0:DEPTH-1];
    logic [ADDR_W:0] pc;
    logic [ADDR_W:0] len;
    logic            issued;
    logic [ADDR_W:0] sel;
    logic [33:0]     word;

    // Program memory is not reset; writes only land while idle so a running
    // program can never be modified under the processor.
    always_ff @(posedge clk) begin
        if (load_en && !busy) begin
            mem[load_addr] <= load_data;
        end
    end

    // Once the current word has been issued, a high done means the processor
    // restarts at this edge, so look one entry ahead. Keeping this path
    // combinational is what lets back-to-back instructions issue with no gap.
    always_comb begin
        sel  = (issued && bus.done) ? pc + ONE : pc;
        word = IDLE_WORD;
        if (busy && (sel < len)) begin
            word = mem[sel[ADDR_W-1:0]];
        end
    end

    assign bus.instr     = word[33:31];
    assign bus.reg1      = word[30:26];
    assign bus.reg2      = word[25:21];
    assign bus.reg3      = word[20:16];
    assign bus.const_val = word[15:0];

`ifdef ISSUE_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt;

    // Counts consecutive stalled busy cycles; any done edge clears it.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.done || !busy) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    // The watchdog limit has no meaning without the counter.
    assign timeout_err = (TIMEOUT < 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            pc          <= '0;
            issued      <= 1'b0;
            issue_count <= '0;
            finished    <= 1'b0;
`ifdef ISSUE_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
        end else if (!busy) begin
            if (start) begin
                // An empty program completes on the start edge itself.
                busy        <= (prog_len != '0);
                finished    <= (prog_len == '0);
                len         <= prog_len;
                pc          <= '0;
                issued      <= 1'b0;
                issue_count <= '0;
`ifdef ISSUE_TIMEOUT_EN
                timeout_err <= 1'b0;
`endif
            end
`ifdef ISSUE_TIMEOUT_EN
        end else if (!bus.done && (to_cnt == TO_LAST)) begin
            // Abandon the run; the bus falls back to the idle word.
            busy        <= 1'b0;
            finished    <= 1'b0;
            timeout_err <= 1'b1;
`endif
        end else if (bus.done) begin
            if (sel < len) begin
                pc          <= sel;
                issued      <= 1'b1;
                issue_count <= issue_count + ONE;
            end else if (issued) begin
                // Last word completed; the processor starts the idle read now.
                busy     <= 1'b0;
                finished <= 1'b1;
            end
        end
    end

endmodule
